// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and sizing for the iterative divider
package seq_divider_pkg;

  // Controller states: waiting for a request, iterating, presenting results.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 32;

  // Step counter must hold WIDTH-1.
  localparam int DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH);

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one restoring compare/subtract step
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   t_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  // One extra bit beyond T so the top bit is the borrow: clear means T >= divisor.
  logic [WIDTH+1:0] diff;
  logic             unused_diff_msb;

  // Subtract, then keep either the difference or the untouched partial remainder.
  always_comb begin
    diff    = {1'b0, t_i} - {2'b00, divisor_i};
    q_bit_o = ~diff[WIDTH+1];
    rem_o   = q_bit_o ? diff[WIDTH-1:0] : t_i[WIDTH-1:0];
  end

  // A non-borrowing difference is below the divisor, so bit WIDTH is always zero.
  assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative unsigned divider with start/done handshake
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] dvs_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic             dbz_q;

  logic [WIDTH:0]   t_d;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic             q_bit;

  // Partial remainder shifted left with the next dividend bit; R's MSB is always
  // zero entering a step, so the WIDTH+1-bit value never loses information.
  assign t_d = {r_q, q_q[WIDTH-1]};

  div_step #(.WIDTH(WIDTH)) u_step (
    .t_i       (t_d),
    .divisor_i (dvs_q),
    .rem_o     (r_d),
    .q_bit_o   (q_bit)
  );

  assign q_d = {q_q[WIDTH-2:0], q_bit};

  // Controller, iteration registers and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (divisor == '0) begin
              // Divide by zero resolves immediately without iterating.
              quo_q   <= '1;
              rem_q   <= dividend;
              dbz_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              dvs_q   <= divisor;
              r_q     <= '0;
              q_q     <= dividend;
              cnt_q   <= CW'(WIDTH - 1);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            quo_q   <= q_d;
            rem_q   <= r_d;
            dbz_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles of busy left after each edge, plus held and pending results.
  int           m_left = 0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_z = 1'b0;
  logic [W-1:0] p_q = '0;
  logic [W-1:0] p_r = '0;
  logic         p_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left = 0;
      m_q = '0;
      m_r = '0;
      m_z = 1'b0;
    end else begin
      if (m_left != 0) begin
        m_left = m_left - 1;
      end else if (start) begin
        if (divisor == '0) begin
          p_q = '1;
          p_r = dividend;
          p_z = 1'b1;
          m_left = 1;
        end else begin
          p_q = dividend / divisor;
          p_r = dividend % divisor;
          p_z = 1'b0;
          m_left = W + 1;
        end
      end
      if (m_left == 1) begin
        m_q = p_q;
        m_r = p_r;
        m_z = p_z;
      end
    end
  end

  // Every cycle: handshake and held results against the model.
  always @(negedge clk) begin
    check("busy", W'(busy), W'(m_left != 0));
    check("done", W'(done), W'(m_left == 1));
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", W'(div_by_zero), W'(m_z));
  end

  // Wait (bounded) for done after the accept edge; returns edges elapsed.
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL done_timeout: actual=none required=pulse at %0t", $time);
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                        input string tag);
    int n;
    @(posedge clk);
    #2;
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(n);
    check({tag, "_latency"}, W'(n), (b == '0) ? W'(0) : W'(W));
    check({tag, "_q"}, quotient, eq);
    check({tag, "_r"}, remainder, er);
    check({tag, "_dbz"}, W'(ez), W'(div_by_zero));
    @(posedge clk);
    #2;
    check({tag, "_done_one_cycle"}, W'(done), W'(0));
    check({tag, "_idle"}, W'(busy), W'(0));
  endtask

  initial begin
    int n;
    logic [W-1:0] a;
    logic [W-1:0] b;

    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", W'(busy), W'(0));
    check("reset_done", W'(done), W'(0));
    check("reset_q", quotient, W'(0));
    check("reset_r", remainder, W'(0));
    check("reset_dbz", W'(div_by_zero), W'(0));
    rst_n = 1'b1;

    run_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, "d100_7");
    run_op(32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, "max_1");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, "max_max");
    run_op(32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, "div0");
    run_op(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "d9_3");
    run_op(32'd7, 32'd100, 32'd0, 32'd7, 1'b0, "small_big");
    run_op(32'hFFFFFFFF, 32'hC0000000, 32'd1, 32'h3FFFFFFF, 1'b0, "big_div");

    // Start while busy must be ignored.
    @(posedge clk);
    #2;
    dividend = 32'd100;
    divisor = 32'd7;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    dividend = 32'd50;
    divisor = 32'd5;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_done(n);
    check("ignored_start_latency", W'(n), W'(W - 11));
    check("ignored_start_q", quotient, 32'd14);
    check("ignored_start_r", remainder, 32'd2);
    @(posedge clk);
    #2;

    // Asynchronous reset mid-operation.
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #2;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", W'(busy), W'(0));
    check("midrst_done", W'(done), W'(0));
    check("midrst_q", quotient, W'(0));
    check("midrst_r", remainder, W'(0));
    check("midrst_dbz", W'(div_by_zero), W'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    run_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, "d1000_3");

    // Random operands, divisor non-zero with a spread of magnitudes.
    for (int i = 0; i < 500; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'd1;
      run_op(a, b, a / b, a % b, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
